cpu_trace_serializer: RTL

Upstream feeder for `cpu_checker`. Accepts one CPU write-back record (time, PC, and either a register or a memory write) through a valid/ready handshake. Emits the record as ASCII text, one character per clock, on `char`. The text format is the one `cpu_checker` validates: `^<time>@<pc>: $<grf> <= <data>#` for register writes, and `^<time>@<pc>: *<addr> <= <data>#` for memory writes.

---
 rtl/cpu_trace_serializer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer: turns one CPU write-back record into the ASCII line
// "^<time>@<pc>: $<grf> <= <data>#" or "^<time>@<pc>: *<addr> <= <data>#",
// one character per clock on a registered char output.
// Decimal digits are computed at capture, so the field walk never stalls.
module cpu_trace_serializer #(
  parameter logic [7:0] IDLE_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic        in_is_mem,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        busy
);

  // One state per field of the text line; sub_q walks the digits of a field.
  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_KIND,
    S_LOC, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sub_q, sub_d;
  logic [7:0]  char_q, char_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  // Captured record fields
  logic [31:0]      pc_q, addr_q, data_q;
  logic             is_mem_q;
  logic [3:0][3:0]  t_dig_q;   // index 0 = ones digit
  logic [2:0]       t_len_q;   // 1..4 digits
  logic [1:0][3:0]  g_dig_q;   // index 0 = ones digit
  logic [2:0]       g_len_q;   // 1..2 digits

  // Decimal conversion of the incoming record
  logic [13:0]      t_sat_s;
  logic [3:0][3:0]  t_dig_s;
  logic [2:0]       t_len_s;
  logic [1:0][3:0]  g_dig_s;
  logic [2:0]       g_len_s;
  logic             accept_s;

  function automatic logic [3:0] dec_digit(input logic [13:0] v, input logic [13:0] div);
    return 4'((v / div) % 14'd10);
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  // Lowercase hex: 'a' is 8'h61, so digits 10..15 start from 8'h57.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h57 + {4'h0, n};
    end
  endfunction

  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  assign accept_s = in_valid && ready_q;

  // Saturate time to 9999 and split time and grf into decimal digits.
  always_comb begin
    if (in_time > 14'd9999) begin
      t_sat_s = 14'd9999;
    end else begin
      t_sat_s = in_time;
    end
    t_dig_s[0] = dec_digit(t_sat_s, 14'd1);
    t_dig_s[1] = dec_digit(t_sat_s, 14'd10);
    t_dig_s[2] = dec_digit(t_sat_s, 14'd100);
    t_dig_s[3] = dec_digit(t_sat_s, 14'd1000);
    if (t_sat_s >= 14'd1000) begin
      t_len_s = 3'd4;
    end else if (t_sat_s >= 14'd100) begin
      t_len_s = 3'd3;
    end else if (t_sat_s >= 14'd10) begin
      t_len_s = 3'd2;
    end else begin
      t_len_s = 3'd1;
    end
    g_dig_s[0] = 4'(in_grf % 5'd10);
    g_dig_s[1] = 4'(in_grf / 5'd10);
    if (in_grf >= 5'd10) begin
      g_len_s = 3'd2;
    end else begin
      g_len_s = 3'd1;
    end
  end

  // Next-state logic: walk the field sequence, restart on accept at '#'.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    case (state_q)
      S_IDLE: begin
        sub_d = 3'd0;
        if (accept_s) begin
          state_d = S_CARET;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CARET: begin
        state_d = S_TIME;
        sub_d   = t_len_q - 3'd1;
      end
      S_TIME: begin
        if (sub_q == 3'd0) begin
          state_d = S_AT;
        end else begin
          sub_d = sub_q - 3'd1;
        end
      end
      S_AT: begin
        state_d = S_PC;
        sub_d   = 3'd7;
      end
      S_PC: begin
        if (sub_q == 3'd0) begin
          state_d = S_COLON;
        end else begin
          sub_d = sub_q - 3'd1;
        end
      end
      S_COLON: state_d = S_SP1;
      S_SP1:   state_d = S_KIND;
      S_KIND: begin
        state_d = S_LOC;
        if (is_mem_q) begin
          sub_d = 3'd7;
        end else begin
          sub_d = g_len_q - 3'd1;
        end
      end
      S_LOC: begin
        if (sub_q == 3'd0) begin
          state_d = S_SP2;
        end else begin
          sub_d = sub_q - 3'd1;
        end
      end
      S_SP2: state_d = S_LT;
      S_LT:  state_d = S_EQ;
      S_EQ:  state_d = S_SP3;
      S_SP3: begin
        state_d = S_DATA;
        sub_d   = 3'd7;
      end
      S_DATA: begin
        if (sub_q == 3'd0) begin
          state_d = S_HASH;
        end else begin
          sub_d = sub_q - 3'd1;
        end
      end
      S_HASH: begin
        sub_d = 3'd0;
        if (accept_s) begin
          state_d = S_CARET;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sub_d   = 3'd0;
      end
    endcase
  end

  // Character and status to be shown during the next cycle.
  always_comb begin
    char_d  = IDLE_CHAR;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) || (state_d == S_HASH);
    case (state_d)
      S_IDLE:  char_d = IDLE_CHAR;
      S_CARET: char_d = 8'h5e;
      S_TIME:  char_d = dec_char(t_dig_q[sub_d[1:0]]);
      S_AT:    char_d = 8'h40;
      S_PC:    char_d = hex_char(nibble(pc_q, sub_d));
      S_COLON: char_d = 8'h3a;
      S_SP1:   char_d = 8'h20;
      S_KIND: begin
        if (is_mem_q) begin
          char_d = 8'h2a;
        end else begin
          char_d = 8'h24;
        end
      end
      S_LOC: begin
        if (is_mem_q) begin
          char_d = hex_char(nibble(addr_q, sub_d));
        end else begin
          char_d = dec_char(g_dig_q[sub_d[0]]);
        end
      end
      S_SP2:   char_d = 8'h20;
      S_LT:    char_d = 8'h3c;
      S_EQ:    char_d = 8'h3d;
      S_SP3:   char_d = 8'h20;
      S_DATA:  char_d = hex_char(nibble(data_q, sub_d));
      S_HASH:  char_d = 8'h23;
      default: char_d = IDLE_CHAR;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sub_q   <= 3'd0;
      char_q  <= IDLE_CHAR;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      char_q  <= char_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Record capture on handshake; later input changes do not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= 32'h0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      is_mem_q <= 1'b0;
      t_dig_q  <= 16'h0;
      t_len_q  <= 3'd0;
      g_dig_q  <= 8'h0;
      g_len_q  <= 3'd0;
    end else if (accept_s) begin
      pc_q     <= in_pc;
      addr_q   <= in_addr;
      data_q   <= in_data;
      is_mem_q <= in_is_mem;
      t_dig_q  <= t_dig_s;
      t_len_q  <= t_len_s;
      g_dig_q  <= g_dig_s;
      g_len_q  <= g_len_s;
    end
  end

  assign char     = char_q;
  assign busy     = busy_q;
  assign in_ready = ready_q;

endmodule
